// File: rtl/alu_shift_logic_seq.sv
// ---------------------------------------------------------------------------
// alu_shift_logic_seq
//
// This is a sequential logical and shift ALU slice. It computes AND, OR, XOR,
// SLL, SRL and SRA on WIDTH-bit operands. Shifts run on an iterative shifter
// that moves up to STEP bits per clock. Operands arrive on an in_valid/in_ready
// handshake, and results leave on an out_valid/out_ready handshake.
//
// Op codes ({sel2,sel1,sel0}):
//   000 AND   001 OR    010 XOR
//   110 SLL   100 SRA   101 SRL
//   011 / 111 reserved: out=0 and op_err=1.
//     When ALU_ROTATE_EN is defined, 011 is ROL and 111 is ROR.
//
// Optional feature macro: ALU_ROTATE_EN
//   Defined   : rotates go through the SHIFT state, and op_err is never set.
//   Undefined : there is no rotate logic, and 011/111 are reserved ops.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands and op are valid
//   in_ready   block can accept an operation (IDLE)
//   in1        operand A; this is the value that is shifted
//   in2        operand B; the shift amount is in2[SAW-1:0]
//   sel        op code
//   out_valid  result is valid (DONE)
//   out_ready  consumer accepts the result
//   out        result
//   op_err     result came from a reserved op code
// ---------------------------------------------------------------------------
module alu_shift_logic_seq #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SAW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             op_err
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  // STEP can equal WIDTH, so the per-cycle amount needs one extra bit
  // beyond SAW.
  localparam logic [SAW:0] STEP_W = (SAW+1)'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] work_reg;
  logic             sign_reg;
  logic [SAW-1:0]   rem_reg;
  logic [WIDTH-1:0] out_reg;
  logic             op_err_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign op_err    = op_err_reg;

  // ---------------------------------------------------------------------
  // Op decode
  // ---------------------------------------------------------------------
  function automatic logic is_rotate(input logic [2:0] op);
`ifdef ALU_ROTATE_EN
    return (op == OP_ROL) || (op == OP_ROR);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || is_rotate(op);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
`ifdef ALU_ROTATE_EN
    return 1'b0;
`else
    return (op == OP_ROL) || (op == OP_ROR);
`endif
  endfunction

  logic [SAW-1:0] amt;
  assign amt = in2[SAW-1:0];

  // This is the result registered directly from IDLE. It covers logic ops,
  // reserved ops and shifts by zero.
  logic [WIDTH-1:0] imm_result;
  always_comb begin
    imm_result = '0;
    case (sel)
      OP_AND:  imm_result = in1 & in2;
      OP_OR:   imm_result = in1 | in2;
      OP_XOR:  imm_result = in1 ^ in2;
      default: imm_result = is_shift(sel) ? in1 : '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative shifter
  //
  // A single right shifter serves every op. For left ops, the word is
  // bit-reversed before and after the shift. The upper half of the
  // double-width shift input supplies the fill: the sign or zeros for
  // shifts, and the word itself for rotates.
  // ---------------------------------------------------------------------
  logic [SAW:0]     s_amt;
  logic [SAW-1:0]   rem_next;
  logic             left_op;
  logic             rot_op;
  logic             fill_bit;
  logic [WIDTH-1:0] work_rev;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] shr_low;
  logic [WIDTH-1:0] shr_rev;
  logic [WIDTH-1:0] shift_result;

  assign s_amt    = ({1'b0, rem_reg} > STEP_W) ? STEP_W : {1'b0, rem_reg};
  assign rem_next = rem_reg - s_amt[SAW-1:0];
  assign rot_op   = is_rotate(op_reg);
  assign left_op  = (op_reg == OP_SLL) || (rot_op && (op_reg == OP_ROL));
  assign fill_bit = (op_reg == OP_SRA) && sign_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign work_rev[gi] = work_reg[WIDTH-1-gi];
    assign shr_rev[gi]  = shr_low[WIDTH-1-gi];
  end

  assign operand      = left_op ? work_rev : work_reg;
  assign upper        = rot_op ? operand : {WIDTH{fill_bit}};
  assign shr_low      = WIDTH'({upper, operand} >> s_amt);
  assign shift_result = left_op ? shr_rev : shr_low;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      work_reg      <= '0;
      sign_reg      <= 1'b0;
      rem_reg       <= '0;
      out_reg       <= '0;
      op_err_reg    <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg       <= sel;
            work_reg     <= in1;
            sign_reg     <= in1[WIDTH-1];
            rem_reg      <= amt;
            in_ready_reg <= 1'b0;
            if (is_shift(sel) && (amt != '0)) begin
              state_reg <= SHIFT;
            end else begin
              out_reg       <= imm_result;
              op_err_reg    <= is_reserved(sel);
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        SHIFT: begin
          work_reg <= shift_result;
          rem_reg  <= rem_next;
          if (rem_next == '0) begin
            out_reg       <= shift_result;
            op_err_reg    <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_logic_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_shift_logic_seq
//
// This bench drives directed and random operations through alu_shift_logic_seq
// (WIDTH=32, STEP=4). It checks result, op_err, latency and handshake
// behaviour against a reference model built from plain SV operators.
// ---------------------------------------------------------------------------
module tb_alu_shift_logic_seq;

  localparam int W    = 32;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic [2:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_w;
  logic          op_err;

  int errors = 0;
  int checks = 0;

  alu_shift_logic_seq #(.WIDTH(W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: result, error flag and the cycle count from acceptance
  // until out_valid is first seen high.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2:0] op, output logic [W-1:0] r,
                                output logic e, output int lat);
    int amt;
    amt = int'(b[4:0]);
    r   = '0;
    e   = 1'b0;
    lat = 1;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a ^ b;
      3'b110: r = a << amt;
      3'b101: r = a >> amt;
      3'b100: r = W'($signed(a) >>> amt);
`ifdef ALU_ROTATE_EN
      3'b011: r = (amt == 0) ? a : ((a << amt) | (a >> (W - amt)));
      3'b111: r = (amt == 0) ? a : ((a >> amt) | (a << (W - amt)));
`else
      default: begin r = '0; e = 1'b1; end
`endif
    endcase
`ifdef ALU_ROTATE_EN
    if (op != 3'b000 && op != 3'b001 && op != 3'b010 && amt != 0)
`else
    if ((op == 3'b110 || op == 3'b101 || op == 3'b100) && amt != 0)
`endif
      lat = 1 + (amt + STEP - 1) / STEP;
  endfunction

  // Run one operation end to end, holding out_ready low for 'hold' cycles
  // once the result is presented.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input int hold);
    logic [W-1:0] exp_r;
    logic         exp_e;
    int           exp_lat;
    int           k;
    logic [W-1:0] held;
    model(a, b, op, exp_r, exp_e, exp_lat);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    in_valid  = 1'b1;
    in1       = a;
    in2       = b;
    sel       = op;
    out_ready = 1'b0;
    @(negedge clk);
    k = 1;
    while (out_valid !== 1'b1 && k < 64) begin
      check("busy_in_ready", in_ready, 0);
      // Junk operands and out_ready toggles must be ignored while busy.
      in_valid  = 1'($urandom);
      in1       = $urandom;
      in2       = $urandom;
      sel       = 3'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    if (out_valid !== 1'b1) begin
      check("timeout", 0, 1);
      return;
    end
    check("latency", 64'(k), 64'(exp_lat));
    check("out", out_w, exp_r);
    check("op_err", op_err, exp_e);
    held = out_w;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in1      = $urandom;
      in2      = $urandom;
      sel      = 3'($urandom);
      @(negedge clk);
      check("hold_out", out_w, held);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    $display("op sel=%b in1=%08h in2=%08h out=%08h err=%0b lat=%0d", op, a, b, held, op_err, k);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in1       = 32'hDEAD_BEEF;
    in2       = 32'h3;
    sel       = 3'b110;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_w, 0);
    check("rst_op_err", op_err, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Directed cases
    run_op(32'h0000_0001, 32'h0000_0001, 3'b000, 0);
    run_op(32'h0000_0001, 32'h0000_0001, 3'b001, 0);
    run_op(32'h0000_0001, 32'h0000_0000, 3'b010, 0);
    run_op(32'h0000_0030, 32'd5, 3'b110, 0);
    run_op(32'h0000_0030, 32'd0, 3'b110, 0);
    run_op(32'h8000_000F, 32'd4, 3'b100, 0);
    run_op(32'h8000_000F, 32'd4, 3'b101, 0);
    run_op(32'hA5A5_5A5A, 32'h0F0F_F0F0, 3'b010, 5);
    run_op(32'h8000_0001, 32'd1, 3'b011, 0);
    run_op(32'h8000_0001, 32'd1, 3'b111, 0);
    run_op(32'h8000_0000, 32'd31, 3'b100, 1);
    run_op(32'hFFFF_FFFF, 32'd31, 3'b110, 0);

    // Abort mid-SHIFT: no result may appear afterwards.
    @(negedge clk);
    in_valid = 1'b1;
    in1      = 32'h1234_5678;
    in2      = 32'd31;
    sel      = 3'b110;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_out", out_w, 0);
    check("abort_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      check("abort_out_valid", out_valid, 0);
      @(negedge clk);
    end
    $display("abort mid-shift: out_valid=%0b in_ready=%0b", out_valid, in_ready);

    // Random ops
    for (int i = 0; i < 200; i++)
      run_op($urandom, $urandom, 3'($urandom), int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
